exposure_ctrl_n: RTL and testbench

- Parametrised exposure/readout sequencer for the pixel array: erase, timed exposure, then row-by-row readout with an ADC strobe per row.
- Generalises the fixed two-row exposure FSM in four ways: NROWS readout rows, a programmable and saturating exposure time, a single-shot/continuous mode, and a frame-done pulse.
- Sits between the user controls (Init, exposure up/down, mode) and the pixel-array/ADC control lines.

---
 rtl/exposure_ctrl_n.sv | 182 ++++++++++++++++++
 tb/tb_exposure_ctrl_n.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exposure_ctrl_n.sv
// ---------------------------------------------------------------------------
// exposure_ctrl_n
//   Exposure/readout sequencer for the pixel array. Each frame holds the
//   array in erase, exposes it for a programmable time, then reads it out
//   row by row with one ADC convert strobe per row. Frames start on an Init
//   edge (single shot) or repeat on their own while Cont is high.
//
// Ports
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   Init         in   start request (rising edge detected internally)
//   Exp_increase in   rising edge: exposure time +1 unit (saturating)
//   Exp_decrease in   rising edge: exposure time -1 unit (saturating)
//   Cont         in   1 = continuous frames, 0 = single shot
//   Erase        out  pixel erase, high while idle
//   Expose       out  high during exposure
//   NRE          out  active-low row read enables, bit r selects row r
//   ADC          out  ADC convert strobe
//   Busy         out  high whenever a frame is in progress
//   Frame_done   out  one-cycle pulse after the last row is read
//   Exp_time     out  current exposure setting in units
// ---------------------------------------------------------------------------
module exposure_ctrl_n #(
    parameter int NROWS          = 2,
    parameter int EXP_W          = 5,
    parameter int EXP_MIN        = 2,
    parameter int EXP_MAX        = 30,
    parameter int EXP_DEFAULT    = 4,
    parameter int TICKS_PER_UNIT = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Init,
    input  logic             Exp_increase,
    input  logic             Exp_decrease,
    input  logic             Cont,
    output logic             Erase,
    output logic             Expose,
    output logic [NROWS-1:0] NRE,
    output logic             ADC,
    output logic             Busy,
    output logic             Frame_done,
    output logic [EXP_W-1:0] Exp_time
);

    // Wide enough for EXP_MAX * TICKS_PER_UNIT, so the load never wraps.
    localparam int CW = EXP_W + $clog2(TICKS_PER_UNIT) + 1;
    localparam int RW = (NROWS > 1) ? $clog2(NROWS) : 1;

    localparam logic [CW-1:0]    TPU_C     = CW'(TICKS_PER_UNIT);
    localparam logic [RW-1:0]    LAST_ROW  = RW'(NROWS - 1);
    localparam logic [EXP_W-1:0] EXP_MIN_C = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0] EXP_MAX_C = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] EXP_DEF_C = EXP_W'(EXP_DEFAULT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPOSE  = 2'd1,
        READOUT = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [RW-1:0]    row, row_n;
    logic [1:0]       phase, phase_n;
    logic [EXP_W-1:0] exp_time, exp_n;
    logic             frame_done, frame_done_n;
    logic             auto_start, auto_start_n;

    logic init_q, inc_q, dec_q;
    logic init_edge, inc_edge, dec_edge;

    // Saturating one-unit step of the exposure setting. Opposing edges in
    // the same cycle cancel.
    function automatic logic [EXP_W-1:0] exp_step(input logic [EXP_W-1:0] cur,
                                                  input logic up,
                                                  input logic dn);
        logic [EXP_W-1:0] res;
        res = cur;
        if (up && !dn) begin
            res = (cur >= EXP_MAX_C) ? EXP_MAX_C : cur + 1'b1;
        end else if (dn && !up) begin
            res = (cur <= EXP_MIN_C) ? EXP_MIN_C : cur - 1'b1;
        end
        return res;
    endfunction

    assign init_edge = Init & ~init_q;
    assign inc_edge  = Exp_increase & ~inc_q;
    assign dec_edge  = Exp_decrease & ~dec_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            row        <= '0;
            phase      <= '0;
            exp_time   <= EXP_DEF_C;
            frame_done <= 1'b0;
            auto_start <= 1'b0;
            init_q     <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            row        <= row_n;
            phase      <= phase_n;
            exp_time   <= exp_n;
            frame_done <= frame_done_n;
            auto_start <= auto_start_n;
            init_q     <= Init;
            inc_q      <= Exp_increase;
            dec_q      <= Exp_decrease;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        row_n        = row;
        phase_n      = phase;
        exp_n        = exp_time;
        frame_done_n = 1'b0;
        auto_start_n = auto_start;

        case (state)
            IDLE: begin
                // The setting only moves while idle; the updated value is
                // the one loaded if this same cycle starts a frame.
                exp_n = exp_step(exp_time, inc_edge, dec_edge);
                if (init_edge || auto_start) begin
                    state_n      = EXPOSE;
                    cnt_n        = CW'(exp_n) * TPU_C;
                    auto_start_n = 1'b0;
                end
            end
            EXPOSE: begin
                cnt_n = cnt - 1'b1;
                if (cnt <= CW'(1)) begin
                    state_n = READOUT;
                    row_n   = '0;
                    phase_n = '0;
                end
            end
            READOUT: begin
                if (phase == 2'd2) begin
                    phase_n = '0;
                    if (row == LAST_ROW) begin
                        state_n      = IDLE;
                        frame_done_n = 1'b1;
                        // Cont is captured here; a set flag forces exactly
                        // one idle (erase) cycle before the next exposure.
                        auto_start_n = Cont;
                    end else begin
                        row_n = row + 1'b1;
                    end
                end else begin
                    phase_n = phase + 2'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        Erase      = (state == IDLE);
        Expose     = (state == EXPOSE);
        Busy       = (state != IDLE);
        ADC        = (state == READOUT) && (phase == 2'd1);
        Frame_done = frame_done;
        Exp_time   = exp_time;
        NRE        = '1;
        for (int r = 0; r < NROWS; r++) begin
            NRE[r] = ~((state == READOUT) && (phase != 2'd2) && (row == RW'(r)));
        end
    end

endmodule

// File: tb/tb_exposure_ctrl_n.sv
// ---------------------------------------------------------------------------
// tb_exposure_ctrl_n
//   Directed bench for exposure_ctrl_n. Instance u_dut_a uses the default
//   parameters (2 rows, 1 tick per unit); u_dut_b uses 4 rows and 3 ticks
//   per unit for the continuous-mode frames.
// ---------------------------------------------------------------------------
module tb_exposure_ctrl_n;

    logic       clk;
    logic       rst;

    logic       init_a, inc_a, dec_a, cont_a;
    logic       erase_a, expose_a, adc_a, busy_a, fd_a;
    logic [1:0] nre_a;
    logic [4:0] exp_a;

    logic       init_b, inc_b, dec_b, cont_b;
    logic       erase_b, expose_b, adc_b, busy_b, fd_b;
    logic [3:0] nre_b;
    logic [4:0] exp_b;

    int n_tests = 0;
    int n_fail  = 0;

    exposure_ctrl_n u_dut_a (
        .Clk          (clk),
        .Reset        (rst),
        .Init         (init_a),
        .Exp_increase (inc_a),
        .Exp_decrease (dec_a),
        .Cont         (cont_a),
        .Erase        (erase_a),
        .Expose       (expose_a),
        .NRE          (nre_a),
        .ADC          (adc_a),
        .Busy         (busy_a),
        .Frame_done   (fd_a),
        .Exp_time     (exp_a)
    );

    exposure_ctrl_n #(
        .NROWS          (4),
        .TICKS_PER_UNIT (3)
    ) u_dut_b (
        .Clk          (clk),
        .Reset        (rst),
        .Init         (init_b),
        .Exp_increase (inc_b),
        .Exp_decrease (dec_b),
        .Cont         (cont_b),
        .Erase        (erase_b),
        .Expose       (expose_b),
        .NRE          (nre_b),
        .ADC          (adc_b),
        .Busy         (busy_b),
        .Frame_done   (fd_b),
        .Exp_time     (exp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic up, input logic dn);
        inc_a = up;
        dec_a = dn;
        tick();
        inc_a = 1'b0;
        dec_a = 1'b0;
        tick();
    endtask

    // One single-shot frame on u_dut_a. n_exp is the expected exposure
    // length; noise toggles Init and Exp_increase throughout the frame.
    task automatic frame_a(input string tag, input int n_exp, input bit noise, input bit with_inc);
        logic [1:0] nre_tbl [6];
        logic       adc_tbl [6];
        nre_tbl = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b11};
        adc_tbl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        check({tag, " idle before"}, {busy_a, erase_a}, 2'b01);
        init_a = 1'b1;
        inc_a  = with_inc;
        tick();
        init_a = 1'b0;
        inc_a  = 1'b0;
        for (int k = 0; k < n_exp; k++) begin
            check({tag, " expose"}, {expose_a, erase_a, busy_a, nre_a, adc_a}, 6'b101110);
            if (noise) begin
                init_a = k[0];
                inc_a  = k[0];
            end
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            check({tag, " readout nre"}, nre_a, nre_tbl[k]);
            check({tag, " readout adc"}, adc_a, adc_tbl[k]);
            check({tag, " readout ctl"}, {expose_a, busy_a, erase_a}, 3'b010);
            if (noise) begin
                init_a = k[0];
                inc_a  = k[0];
            end
            tick();
        end
        init_a = 1'b0;
        inc_a  = 1'b0;
        check({tag, " frame_done"}, {fd_a, erase_a, busy_a, expose_a}, 4'b1100);
        tick();
        check({tag, " after done"}, {fd_a, erase_a, busy_a, expose_a}, 4'b0100);
    endtask

    initial begin
        rst    = 1'b0;
        init_a = 1'b0; inc_a = 1'b0; dec_a = 1'b0; cont_a = 1'b0;
        init_b = 1'b0; inc_b = 1'b0; dec_b = 1'b0; cont_b = 1'b0;

        // Asynchronous reset between edges.
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst erase",  erase_a, 1'b1);
        check("rst expose", expose_a, 1'b0);
        check("rst nre",    nre_a, 2'b11);
        check("rst adc",    adc_a, 1'b0);
        check("rst busy",   busy_a, 1'b0);
        check("rst fd",     fd_a, 1'b0);
        check("rst exp",    exp_a, 5'd4);
        check("rst nre_b",  nre_b, 4'hF);
        #2 rst = 1'b0;
        tick();

        frame_a("dflt", 4, 1'b0, 1'b0);
        check("dflt exp", exp_a, 5'd4);

        frame_a("busy", 4, 1'b1, 1'b0);
        check("busy exp", exp_a, 5'd4);

        // Saturation of the exposure setting.
        repeat (30) pulse_a(1'b1, 1'b0);
        check("sat max", exp_a, 5'd30);
        repeat (40) pulse_a(1'b0, 1'b1);
        check("sat min", exp_a, 5'd2);
        pulse_a(1'b1, 1'b0);
        check("inc one", exp_a, 5'd3);
        pulse_a(1'b1, 1'b1);
        check("inc dec same", exp_a, 5'd3);
        inc_a = 1'b1;
        repeat (4) tick();
        check("held inc", exp_a, 5'd4);
        inc_a = 1'b0;
        tick();

        // Init and increase edge together: new value used for this frame.
        frame_a("initinc", 5, 1'b0, 1'b1);
        check("initinc exp", exp_a, 5'd5);

        // Reset during row 1, phase 1.
        init_a = 1'b1;
        tick();
        init_a = 1'b0;
        repeat (9) tick();
        check("mid adc pre", adc_a, 1'b1);
        check("mid nre pre", nre_a, 2'b01);
        #2 rst = 1'b1;
        #1;
        check("mid rst adc", adc_a, 1'b0);
        check("mid rst nre", nre_a, 2'b11);
        check("mid rst ctl", {busy_a, erase_a, expose_a, fd_a}, 4'b0100);
        check("mid rst exp", exp_a, 5'd4);
        #1 rst = 1'b0;
        tick();
        frame_a("post", 4, 1'b0, 1'b0);

        // Continuous frames on u_dut_b with Exp_time = 2 (6 ticks).
        repeat (2) begin
            dec_b = 1'b1;
            tick();
            dec_b = 1'b0;
            tick();
        end
        check("b exp", exp_b, 5'd2);
        cont_b = 1'b1;
        init_b = 1'b1;
        tick();
        init_b = 1'b0;
        for (int f = 0; f < 3; f++) begin
            if (f == 2) cont_b = 1'b0;
            for (int k = 0; k < 6; k++) begin
                check("b expose", {expose_b, erase_b, busy_b, nre_b}, 7'b1011111);
                tick();
            end
            for (int r = 0; r < 4; r++) begin
                for (int p = 0; p < 3; p++) begin
                    logic [3:0] e;
                    e = 4'hF;
                    if (p != 2) e[r] = 1'b0;
                    check("b nre", nre_b, e);
                    check("b adc", adc_b, (p == 1));
                    check("b busy", {busy_b, expose_b}, 2'b10);
                    tick();
                end
            end
            check("b frame_done", {fd_b, erase_b, busy_b, expose_b}, 4'b1100);
            tick();
        end
        check("b stop", {fd_b, erase_b, busy_b, expose_b}, 4'b0100);
        tick();
        check("b stay idle", {fd_b, erase_b, busy_b, expose_b}, 4'b0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
